// File: rtl/glitch_cmd_regs.sv
// rtl/glitch_cmd_regs.sv - UART command decoder and register file for the glitcher.
// Handles register write/read-back, arm/disarm, info reply, inter-byte timeout and error pulses.
module glitch_cmd_regs #(
  parameter int NUM_REGS = 4,
  parameter int REG_BYTES = 8,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter logic [NUM_REGS*8*REG_BYTES-1:0] RESET_VALUES = '0,
  parameter logic [7:0] INFO_REPLY = 8'hDE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_ready,
  input  logic [7:0]                      rxd,
  input  logic                            tx_ready,
  output logic                            tx_valid,
  output logic [7:0]                      txd,
  output logic [NUM_REGS*8*REG_BYTES-1:0] regs_flat,
  output logic [NUM_REGS-1:0]             reg_update,
  output logic                            armed,
  input  logic                            arm_clr,
  output logic                            cmd_error
);

  localparam int W  = 8 * REG_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_READBACK,
    S_REPLY
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REGS*W-1:0]   regs_q, regs_d;
  logic [W-1:0]            shift_q, shift_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              txd_q, txd_d;
  logic [NUM_REGS-1:0]     reg_update_q, reg_update_d;
  logic                    cmd_error_q, cmd_error_d;
  logic                    armed_q, armed_d;

  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    tx_valid_d   = tx_valid_q;
    txd_d        = txd_q;
    reg_update_d = '0;
    cmd_error_d  = 1'b0;
    armed_d      = armed_q;

    case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          if (rxd[7:4] == 4'h5 || rxd[7:4] == 4'h6) begin
            if ({1'b0, rxd[3:0]} >= 5'(NUM_REGS)) begin
              cmd_error_d = 1'b1;
            end else begin
              idx_d = rxd[3:0];
              cnt_d = '0;
              tmo_d = '0;
              if (rxd[4]) begin
                state_d = S_PAYLOAD;
              end else begin
                // The shift register doubles as the read-back snapshot, already advanced past the first byte.
                state_d    = S_READBACK;
                tx_valid_d = 1'b1;
                txd_d      = regs_q[int'(rxd[3:0])*W + W-8 +: 8];
                shift_d    = regs_q[int'(rxd[3:0])*W +: W] << 8;
              end
            end
          end else if (rxd == 8'hFA) begin
            armed_d = 1'b1;
          end else if (rxd == 8'hFB) begin
            armed_d = 1'b0;
          end else if (rxd == 8'hFC) begin
            state_d    = S_REPLY;
            cnt_d      = '0;
            tx_valid_d = 1'b1;
            txd_d      = INFO_REPLY;
          end
        end
      end

      S_PAYLOAD: begin
        if (rx_ready) begin
          tmo_d   = '0;
          shift_d = (shift_q << 8) | W'(rxd);
          if (cnt_q == 4'(REG_BYTES-1)) begin
            regs_d[int'(idx_q)*W +: W] = (shift_q << 8) | W'(rxd);
            reg_update_d = NUM_REGS'(1) << idx_q;
            state_d      = S_IDLE;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
          state_d     = S_IDLE;
          cmd_error_d = 1'b1;
          tmo_d       = '0;
          cnt_d       = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_READBACK: begin
        if (rx_ready) cmd_error_d = 1'b1;
        if (tx_ready) begin
          if (cnt_q == 4'(REG_BYTES-1)) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            txd_d   = shift_q[W-1 -: 8];
            shift_d = shift_q << 8;
          end
        end
      end

      S_REPLY: begin
        if (rx_ready) cmd_error_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
          cnt_d      = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The done pulse from the glitcher has priority over an arm command in the same cycle.
    if (arm_clr) armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      regs_q       <= RESET_VALUES;
      shift_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      tx_valid_q   <= 1'b0;
      txd_q        <= '0;
      reg_update_q <= '0;
      cmd_error_q  <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      tx_valid_q   <= tx_valid_d;
      txd_q        <= txd_d;
      reg_update_q <= reg_update_d;
      cmd_error_q  <= cmd_error_d;
      armed_q      <= armed_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign txd        = txd_q;
  assign regs_flat  = regs_q;
  assign reg_update = reg_update_q;
  assign cmd_error  = cmd_error_q;
  assign armed      = armed_q;

endmodule
